// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_e;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a registered copy for edge detection.
// The edge direction follows from the synchronised level reported alongside the edge flag.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign edge_o = sync_q[1] ^ prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register-access slave: frames of R/W bit, address and data, MSB first,
// decoded in the system clock domain into single-cycle register-file strobes.
module spi_reg_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              frame_err_o
);
  import spi_pkg::*;

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int SHIFT_W   = ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic sclkSync, sclkEdge, csSync, csEdge;
  logic [1:0] mosiSync_q;

  spi_sync_edge #(.RESET_VAL(CPOL)) uSclkSync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (sclk_i),
    .sync_o    (sclkSync),
    .edge_o    (sclkEdge)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) uCsSync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (cs_n_i),
    .sync_o    (csSync),
    .edge_o    (csEdge)
  );

  logic leadEdge, trailEdge, sampleEdge, shiftEdge, csRise, mosiBit;

  // The leading edge moves SCLK away from its idle level.
  assign leadEdge   = sclkEdge && (sclkSync != CPOL);
  assign trailEdge  = sclkEdge && (sclkSync == CPOL);
  assign sampleEdge = CPHA ? trailEdge : leadEdge;
  assign shiftEdge  = CPHA ? leadEdge : trailEdge;
  assign csRise     = csEdge && csSync;
  assign mosiBit    = mosiSync_q[1];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
  logic                rw_q, rw_d;
  logic [SHIFT_W-2:0]  inShift_q, inShift_d;
  logic [DATA_W-1:0]   outShift_q, outShift_d;
  logic                miso_q, miso_d;
  logic                wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]   wrData_q, wrData_d;
  logic                rdEn_q, rdEn_d;
  logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
  logic                frameErr_q, frameErr_d;

  logic [SHIFT_W-1:0]  shiftIn;
  logic                lastAddr, lastBit;

  assign shiftIn  = {inShift_q, mosiBit};
  assign lastAddr = (bitCnt_q == CNT_W'(ADDR_W));
  assign lastBit  = (bitCnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mosiSync_q <= '0;
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rw_q       <= WRITE;
      inShift_q  <= '0;
      outShift_q <= '0;
      miso_q     <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      mosiSync_q <= {mosiSync_q[0], mosi_i};
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rw_q       <= rw_d;
      inShift_q  <= inShift_d;
      outShift_q <= outShift_d;
      miso_q     <= miso_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      rdEn_q     <= rdEn_d;
      rdAddr_q   <= rdAddr_d;
      frameErr_q <= frameErr_d;
    end
  end

  // A cs_n rise coinciding with the final data sample still completes the frame.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rw_d       = rw_q;
    inShift_d  = inShift_q;
    outShift_d = outShift_q;
    miso_d     = miso_q;
    wrEn_d     = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    rdEn_d     = 1'b0;
    rdAddr_d   = rdAddr_q;
    frameErr_d = 1'b0;

    if (rdEn_q) outShift_d = rd_data_i;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!csSync) begin
          bitCnt_d = '0;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (csRise) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
        end else if (sampleEdge) begin
          rw_d     = mosiBit;
          bitCnt_d = CNT_W'(1);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (csRise) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
        end else if (sampleEdge) begin
          inShift_d = shiftIn[SHIFT_W-2:0];
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          if (lastAddr) begin
            state_d = DATA;
            if (rw_q == READ) begin
              rdEn_d   = 1'b1;
              rdAddr_d = shiftIn[ADDR_W-1:0];
            end
          end
        end
      end
      DATA: begin
        if (sampleEdge) begin
          inShift_d = shiftIn[SHIFT_W-2:0];
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          if (lastBit) begin
            state_d = DONE;
            if (rw_q == WRITE) begin
              wrEn_d   = 1'b1;
              wrAddr_d = shiftIn[SHIFT_W-1:DATA_W];
              wrData_d = shiftIn[DATA_W-1:0];
            end
          end
        end
        if (csRise && !(sampleEdge && lastBit)) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
          miso_d     = 1'b0;
        end else if (shiftEdge && rw_q == READ) begin
          miso_d     = outShift_q[DATA_W-1];
          outShift_d = outShift_q << 1;
        end
      end
      DONE: begin
        if (csSync) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso_o      = miso_q;
  assign wr_en_o     = wrEn_q;
  assign wr_addr_o   = wrAddr_q;
  assign wr_data_o   = wrData_q;
  assign rd_en_o     = rdEn_q;
  assign rd_addr_o   = rdAddr_q;
  assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: four 4/8-bit instances (SPI modes 0..3) and one 8/16-bit
// instance, driven by an SPI master task and checked against a register-file model.
module tb_spi_reg_slave;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rstN;

  logic sclk[5];
  logic csN[5];
  logic mosi[5];
  logic misoA[5];
  logic wrEnA[5];
  logic rdEnA[5];
  logic errA[5];
  logic [3:0] wrAddrS[4];
  logic [3:0] rdAddrS[4];
  logic [7:0] wrDataS[4];
  logic [7:0] rdDataS[4];
  logic [7:0] wrAddrL, rdAddrL;
  logic [15:0] wrDataL, rdDataL;

  logic [15:0] envMem[5][256];
  logic [15:0] modelMem[5][256];
  bit envReady = 1'b0;

  int wrCnt[5] = '{default: 0};
  int rdCnt[5] = '{default: 0};
  int errCnt[5] = '{default: 0};
  logic [7:0] lastWrAddr[5];
  logic [7:0] lastRdAddr[5];
  logic [15:0] lastWrData[5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : gSmall
    localparam bit POL = (m / 2) == 1;
    localparam bit PHA = (m % 2) == 1;
    spi_reg_slave #(.ADDR_W(4), .DATA_W(8), .CPOL(POL), .CPHA(PHA)) dut (
      .clk_i       (clk),
      .reset_n_i   (rstN),
      .sclk_i      (sclk[m]),
      .cs_n_i      (csN[m]),
      .mosi_i      (mosi[m]),
      .miso_o      (misoA[m]),
      .wr_en_o     (wrEnA[m]),
      .wr_addr_o   (wrAddrS[m]),
      .wr_data_o   (wrDataS[m]),
      .rd_en_o     (rdEnA[m]),
      .rd_addr_o   (rdAddrS[m]),
      .rd_data_i   (rdDataS[m]),
      .frame_err_o (errA[m])
    );
    assign rdDataS[m] = envMem[m][rdAddrS[m]][7:0];
  end

  spi_reg_slave #(.ADDR_W(8), .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0)) dutL (
    .clk_i       (clk),
    .reset_n_i   (rstN),
    .sclk_i      (sclk[4]),
    .cs_n_i      (csN[4]),
    .mosi_i      (mosi[4]),
    .miso_o      (misoA[4]),
    .wr_en_o     (wrEnA[4]),
    .wr_addr_o   (wrAddrL),
    .wr_data_o   (wrDataL),
    .rd_en_o     (rdEnA[4]),
    .rd_addr_o   (rdAddrL),
    .rd_data_i   (rdDataL),
    .frame_err_o (errA[4])
  );
  assign rdDataL = envMem[4][rdAddrL];

  function automatic int addrW(input int i);
    return (i == 4) ? 8 : 4;
  endfunction

  function automatic int dataW(input int i);
    return (i == 4) ? 16 : 8;
  endfunction

  function automatic bit cpolOf(input int i);
    return (i == 4) ? 1'b0 : ((i / 2) == 1);
  endfunction

  function automatic bit cphaOf(input int i);
    return (i == 4) ? 1'b0 : ((i % 2) == 1);
  endfunction

  task automatic noteEvents(input int i, input logic we, input logic [7:0] wa, input logic [15:0] wd,
                            input logic re, input logic [7:0] ra, input logic fe);
    if (we === 1'b1) begin
      wrCnt[i]++;
      lastWrAddr[i] = wa;
      lastWrData[i] = wd;
      envMem[i][wa] = wd;
    end
    if (re === 1'b1) begin
      rdCnt[i]++;
      lastRdAddr[i] = ra;
    end
    if (fe === 1'b1) errCnt[i]++;
  endtask

  // Strobes are counted per high cycle, so a pulse longer than one clk shows up as an extra event.
  always @(negedge clk) begin
    if (!envReady) begin
      for (int i = 0; i < 5; i++)
        for (int a = 0; a < 256; a++) envMem[i][a] = modelMem[i][a];
      envReady = 1'b1;
    end
    for (int i = 0; i < 4; i++)
      noteEvents(i, wrEnA[i], {4'h0, wrAddrS[i]}, {8'h00, wrDataS[i]}, rdEnA[i], {4'h0, rdAddrS[i]}, errA[i]);
    noteEvents(4, wrEnA[4], wrAddrL, wrDataL, rdEnA[4], rdAddrL, errA[4]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // SPI master: sends up to nBits of the frame and records miso at each master sample edge.
  task automatic applyStimulus(input int i, input bit rw, input logic [7:0] addr, input logic [15:0] data,
                               input int nBits, input bit raiseCs, output logic [24:0] misoBits);
    int aw;
    int dw;
    int len;
    bit pol;
    bit pha;
    logic [24:0] frame;
    aw = addrW(i);
    dw = dataW(i);
    len = 1 + aw + dw;
    pol = cpolOf(i);
    pha = cphaOf(i);
    frame = ({24'b0, rw} << (aw + dw)) | ({17'b0, addr} << dw) | {9'b0, data};
    misoBits = '0;
    @(negedge clk);
    csN[i] = 1'b0;
    #HALF;
    for (int b = 0; b < nBits; b++) begin
      logic bitV;
      bitV = frame[len - 1 - b];
      if (!pha) begin
        mosi[i] = bitV;
        #HALF;
        sclk[i] = ~pol;
        misoBits = {misoBits[23:0], misoA[i]};
        #HALF;
        sclk[i] = pol;
      end else begin
        sclk[i] = ~pol;
        mosi[i] = bitV;
        #HALF;
        sclk[i] = pol;
        misoBits = {misoBits[23:0], misoA[i]};
        #HALF;
      end
    end
    if (raiseCs) begin
      #HALF;
      csN[i] = 1'b1;
      mosi[i] = 1'b0;
      #(4 * HALF);
    end
  endtask

  task automatic doWrite(input int i, input logic [7:0] addr, input logic [15:0] data);
    int w0;
    int r0;
    int e0;
    logic [24:0] mb;
    w0 = wrCnt[i];
    r0 = rdCnt[i];
    e0 = errCnt[i];
    applyStimulus(i, 1'b0, addr, data, 1 + addrW(i) + dataW(i), 1'b1, mb);
    checkOutput($sformatf("wrCount[%0d]", i), wrCnt[i] - w0, 1);
    checkOutput($sformatf("wrAddr[%0d]", i), 32'(lastWrAddr[i]), 32'(addr));
    checkOutput($sformatf("wrData[%0d]", i), 32'(lastWrData[i]), 32'(data));
    checkOutput($sformatf("misoWrite[%0d]", i), 32'(mb), 0);
    checkOutput($sformatf("wrNoRd[%0d]", i), rdCnt[i] - r0, 0);
    checkOutput($sformatf("wrNoErr[%0d]", i), errCnt[i] - e0, 0);
    modelMem[i][addr] = data;
  endtask

  task automatic doRead(input int i, input logic [7:0] addr);
    int w0;
    int r0;
    int e0;
    logic [24:0] mb;
    w0 = wrCnt[i];
    r0 = rdCnt[i];
    e0 = errCnt[i];
    applyStimulus(i, 1'b1, addr, 16'h0000, 1 + addrW(i) + dataW(i), 1'b1, mb);
    checkOutput($sformatf("rdCount[%0d]", i), rdCnt[i] - r0, 1);
    checkOutput($sformatf("rdAddr[%0d]", i), 32'(lastRdAddr[i]), 32'(addr));
    checkOutput($sformatf("misoRead[%0d]", i), 32'(mb), 32'(modelMem[i][addr]));
    checkOutput($sformatf("rdNoWr[%0d]", i), wrCnt[i] - w0, 0);
    checkOutput($sformatf("rdNoErr[%0d]", i), errCnt[i] - e0, 0);
  endtask

  initial begin
    logic [7:0] a;
    logic [15:0] d;
    logic [24:0] mb;
    int w0;
    int e0;

    rstN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk[i] = cpolOf(i);
      csN[i] = 1'b1;
      mosi[i] = 1'b0;
      for (int k = 0; k < 256; k++) begin
        logic [31:0] v;
        v = $urandom;
        modelMem[i][k] = (i == 4) ? v[15:0] : {8'h00, v[7:0]};
      end
    end
    modelMem[0][3] = 16'h00C3;

    repeat (3) @(negedge clk);
    checkOutput("rstMiso0", 32'(misoA[0]), 0);
    checkOutput("rstWrEn0", 32'(wrEnA[0]), 0);
    checkOutput("rstRdEn0", 32'(rdEnA[0]), 0);
    checkOutput("rstErr0", 32'(errA[0]), 0);
    checkOutput("rstWrAddr0", 32'(wrAddrS[0]), 0);
    checkOutput("rstWrData0", 32'(wrDataS[0]), 0);
    checkOutput("rstRdAddr0", 32'(rdAddrS[0]), 0);
    checkOutput("rstWrDataL", 32'(wrDataL), 0);
    checkOutput("rstRdAddrL", 32'(rdAddrL), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] basic write and read, mode 0");
    doWrite(0, 8'hA, 16'h5C);
    doRead(0, 8'h3);

    $display("[TB] mode sweep with random register traffic");
    for (int m = 0; m < 4; m++) begin
      doWrite(m, 8'hA, 16'h5C);
      doRead(m, 8'hA);
      for (int r = 0; r < 3; r++) begin
        a = 8'($urandom_range(0, 15));
        d = 16'($urandom_range(0, 255));
        doWrite(m, a, d);
        doRead(m, a);
      end
    end

    $display("[TB] aborted frame after 7 bits");
    w0 = wrCnt[0];
    e0 = errCnt[0];
    applyStimulus(0, 1'b0, 8'h6, 16'h77, 7, 1'b1, mb);
    checkOutput("abortErr", errCnt[0] - e0, 1);
    checkOutput("abortNoWr", wrCnt[0] - w0, 0);
    doWrite(0, 8'h6, 16'h77);

    $display("[TB] reset during write data phase");
    w0 = wrCnt[0];
    e0 = errCnt[0];
    applyStimulus(0, 1'b0, 8'h9, 16'h33, 9, 1'b0, mb);
    rstN = 1'b0;
    #1;
    checkOutput("midRstWrAddr", 32'(wrAddrS[0]), 0);
    checkOutput("midRstWrData", 32'(wrDataS[0]), 0);
    checkOutput("midRstRdAddr", 32'(rdAddrS[0]), 0);
    checkOutput("midRstMiso", 32'(misoA[0]), 0);
    checkOutput("midRstWrEn", 32'(wrEnA[0]), 0);
    checkOutput("midRstErr", 32'(errA[0]), 0);
    csN[0] = 1'b1;
    mosi[0] = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("midRstNoWr", wrCnt[0] - w0, 0);
    checkOutput("midRstNoErr", errCnt[0] - e0, 0);
    doWrite(0, 8'h9, 16'h33);
    doRead(0, 8'h9);

    $display("[TB] wide configuration, back-to-back writes");
    doWrite(4, 8'h81, 16'hBEEF);
    doWrite(4, 8'h7E, 16'h1234);
    doRead(4, 8'h81);
    doRead(4, 8'h7E);
    for (int r = 0; r < 2; r++) begin
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom_range(0, 65535));
      doWrite(4, a, d);
      doRead(4, a);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("misoIdle[%0d]", i), 32'(misoA[i]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
